// File: rtl/sat_arith_pkg.sv
// Shared definitions for the saturating arithmetic datapath blocks.
//
// Contents:
//   state_t        - sequencing states used by the serial arithmetic units
//   DEFAULT_WIDTH  - default operand/result width
//   SAT_MAX_WIDTH  - widest operand the saturation helper can describe
//   sat_pattern()  - saturation value for a given sign and width:
//                    sign=1 -> most negative value (1000...0)
//                    sign=0 -> most positive value (0111...1)
//                    Bits at and above 'width' are zero; callers size-cast
//                    the result down to their own width.
package sat_arith_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int SAT_MAX_WIDTH = 64;

  function automatic logic [SAT_MAX_WIDTH-1:0] sat_pattern(input logic sign, input int width);
    logic [SAT_MAX_WIDTH-1:0] p;
    p = '0;
    for (int i = 0; i < SAT_MAX_WIDTH; i++) begin
      if (i < width - 1) begin
        p[i] = ~sign;
      end else if (i == width - 1) begin
        p[i] = sign;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/sat_sub_bitcell.sv
// One-bit full-adder slice used serially by sat_sub_serial.
//
// Ports:
//   a_i    in  minuend bit
//   nb_i   in  inverted subtrahend bit
//   c      in  carry into this bit (inverted borrow)
//   s      out sum bit
//   c_next out carry out of this bit
module sat_sub_bitcell (
  input  logic a_i,
  input  logic nb_i,
  input  logic c,
  output logic s,
  output logic c_next
);

  assign s      = a_i ^ nb_i ^ c;
  assign c_next = (a_i & nb_i) | (a_i & c) | (nb_i & c);

endmodule

// File: rtl/sat_sub_serial.sv
// Bit-serial signed saturating subtractor: Result = a - b - Bin.
//
// The difference is formed as a + ~b + ~Bin, one bit per clock, LSB first,
// through a single full-adder slice. Signed overflow is carry-into-MSB XOR
// carry-out-of-MSB; on overflow the result saturates toward the sign of a.
//
// Ports:
//   CLK     in  system clock, rising edge
//   RST     in  asynchronous reset, active-high
//   start   in  operation request, sampled only while idle
//   a       in  minuend (signed), captured on accepted start
//   b       in  subtrahend (signed), captured on accepted start
//   Bin     in  borrow in, captured on accepted start
//   busy    out high while an operation is in flight (not in IDLE)
//   done    out one-cycle pulse; Result/Bout/Ovf valid from this cycle on
//   Result  out saturated difference, held until the next done
//   Bout    out unsigned borrow out (inverted final carry)
//   Ovf     out signed overflow flag, held with Result
module sat_sub_serial
  import sat_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Bout,
  output logic             Ovf
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sh;      // minuend, shifted right each SHIFT cycle
  logic [WIDTH-1:0] nb_sh;     // inverted subtrahend, shifted alongside
  logic [WIDTH-1:0] sum_sh;    // sum bits enter at the MSB, LSB first
  logic             c;         // running carry (starts as ~Bin)
  logic             c_msb_in;  // carry into the MSB position
  logic             a_sign;    // sign of the captured minuend, for saturation
  logic [CW-1:0]    cnt;       // index of the bit being processed

  logic             s_bit;
  logic             c_bit;
  logic             last_bit;
  logic             ovf_w;
  logic [WIDTH-1:0] sat_val;

  sat_sub_bitcell u_cell (
    .a_i    (a_sh[0]),
    .nb_i   (nb_sh[0]),
    .c      (c),
    .s      (s_bit),
    .c_next (c_bit)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign ovf_w    = c_msb_in ^ c;
  assign sat_val  = WIDTH'(sat_pattern(a_sign, WIDTH));
  assign busy     = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the default at the top of the block guarantees state_nxt is
  // assigned on every path, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every datapath register, including the operand shift registers,
  // is reset so a mid-operation reset leaves no stale result visible.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sh     <= '0;
      nb_sh    <= '0;
      sum_sh   <= '0;
      c        <= 1'b0;
      c_msb_in <= 1'b0;
      a_sign   <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      Result   <= '0;
      Bout     <= 1'b0;
      Ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= a;
            nb_sh  <= ~b;
            c      <= ~Bin;
            a_sign <= a[WIDTH-1];
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          nb_sh  <= nb_sh >> 1;
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          c      <= c_bit;
          cnt    <= cnt + CW'(1);
          // The carry leaving bit WIDTH-2 is the carry into the MSB.
          if (cnt == CW'(WIDTH - 2)) begin
            c_msb_in <= c_bit;
          end
        end
        FINISH: begin
          Ovf    <= ovf_w;
          Bout   <= ~c;
          Result <= ovf_w ? sat_val : sum_sh;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
